// File: rtl/hexseg_if.sv
// Bus bundle for the multiplexed hex display scanner: shadow-load inputs,
// live display controls and the registered anode/segment drive.
interface hexseg_if #(
  parameter int DIGITS = 4
);
  // load is a one-cycle strobe with no ready: value/dp are captured on the
  // rising edge where load is high, every time, with no back-pressure.
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic [DIGITS-1:0]   dig_en;
  logic                lzb;
  logic [DIGITS-1:0]   an;
  logic [6:0]          segs;
  logic                dpo;
  logic                scan_tick;

  modport master (
    output value, dp, load, dig_en, lzb,
    input  an, segs, dpo, scan_tick
  );

  modport slave (
    input  value, dp, load, dig_en, lzb,
    output an, segs, dpo, scan_tick
  );
endinterface

// File: rtl/hexseg_scan.sv
// Time-multiplexed hex display scanner: one digit per DIV-cycle slot, with a
// dead band at the start of each slot and optional leading-zero blanking.
module hexseg_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 100000,
  parameter int DEAD   = 16
) (
  input logic     clk,
  input logic     rst_n,
  hexseg_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic                wrap;

  logic [DIGITS-1:0] an_q, nxt_an;
  logic [6:0]        segs_q, nxt_segs;
  logic              dpo_q, nxt_dpo;
  logic              tick_q;

  logic [3:0] cur_nib;
  logic       cur_en;
  logic       cur_dp;
  logic       upper_zero;
  logic       blank;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0001100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b1110010;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign wrap = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else begin
      if (wrap) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp;
      end
    end
  end

  // Blanking is evaluated from live dig_en/lzb every cycle, so a change shows
  // up on the next output update rather than at the next slot boundary.
  always_comb begin
    cur_nib    = 4'h0;
    cur_en     = 1'b0;
    cur_dp     = 1'b0;
    upper_zero = 1'b1;
    nxt_an     = '1;
    nxt_segs   = 7'b1111111;
    nxt_dpo    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur_nib = shadow_val[4*i +: 4];
        cur_en  = bus.dig_en[i];
        cur_dp  = shadow_dp[i];
      end
      if (IW'(i) >= idx && shadow_val[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    blank = !cur_en || (int'(cnt) < DEAD) || (bus.lzb && idx != '0 && upper_zero);
    if (!blank) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (IW'(i) == idx) nxt_an[i] = 1'b0;
      end
      nxt_segs = decode(cur_nib);
      nxt_dpo  = ~cur_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q   <= '1;
      segs_q <= 7'b1111111;
      dpo_q  <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      an_q   <= nxt_an;
      segs_q <= nxt_segs;
      dpo_q  <= nxt_dpo;
      tick_q <= wrap;
    end
  end

  assign bus.an        = an_q;
  assign bus.segs      = segs_q;
  assign bus.dpo       = dpo_q;
  assign bus.scan_tick = tick_q;
endmodule

// File: tb/tb_hexseg_scan.sv
// Directed bench for hexseg_scan with a slot-arithmetic reference model
// checked every cycle, plus hand-computed checkpoints.
module tb_hexseg_scan;
  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int DEAD   = 2;

  logic clk;
  logic rst_n;
  hexseg_if #(.DIGITS(DIGITS)) bus ();

  hexseg_scan #(.DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int          e;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_segs;
  logic        exp_dpo;
  logic        exp_tick;

  // e counts rising edges since reset release; the state seen at edge e+1 is
  // slot position e % DIV of digit (e / DIV) % DIGITS.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e = 0; m_val = '0; m_dp = '0;
      exp_an = '1; exp_segs = 7'b1111111; exp_dpo = 1'b1; exp_tick = 1'b0;
    end else begin
      int c, d;
      logic dark;
      logic [15:0] upper;
      c = e % DIV;
      d = (e / DIV) % DIGITS;
      upper = m_val >> (4 * d);
      dark = !bus.dig_en[d] || (c < DEAD) || (bus.lzb && d != 0 && upper == 16'h0);
      exp_tick = (c == DIV - 1);
      if (dark) begin
        exp_an = '1; exp_segs = 7'b1111111; exp_dpo = 1'b1;
      end else begin
        exp_an = ~(4'b0001 << d); exp_segs = seg_tab[upper[3:0]]; exp_dpo = ~m_dp[d];
      end
      if (bus.load) begin
        m_val = bus.value; m_dp = bus.dp;
      end
      e++;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s @%0t: got %b want %b", nm, $time, act[6:0], want[6:0]);
    end
  endtask

  task automatic check_out(input string nm, input logic [3:0] a, input logic [6:0] s, input logic d);
    chk({nm, ".an"},   32'(bus.an),   32'(a));
    chk({nm, ".segs"}, 32'(bus.segs), 32'(s));
    chk({nm, ".dpo"},  32'(bus.dpo),  32'(d));
  endtask

  always @(negedge clk) begin
    chk("model.an",   32'(bus.an),        32'(exp_an));
    chk("model.segs", 32'(bus.segs),      32'(exp_segs));
    chk("model.dpo",  32'(bus.dpo),       32'(exp_dpo));
    chk("model.tick", 32'(bus.scan_tick), 32'(exp_tick));
  end

  // ---------------- driver tasks ----------------
  task automatic goto_edge(input int n);
    int guard = 0;
    while (e < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (e < n) begin
      total++; bad++;
      $display("FAIL goto_edge: reached %0d want %0d", e, n);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.value = '0; bus.dp = '0; bus.load = 1'b0; bus.dig_en = 4'hF; bus.lzb = 1'b0;
    repeat (3) @(negedge clk);
    check_out("reset_hold", 4'b1111, 7'b1111111, 1'b1);
    chk("reset_tick", 32'(bus.scan_tick), 32'd0);

    // basic scan of 1A3F
    rst_n = 1'b1; bus.load = 1'b1; bus.value = 16'h1A3F;
    @(negedge clk); bus.load = 1'b0;
    goto_edge(2);  check_out("dead0", 4'b1111, 7'b1111111, 1'b1);
    goto_edge(3);  check_out("dig0_F", 4'b1110, 7'b0111000, 1'b1);
    goto_edge(8);  chk("tick8", 32'(bus.scan_tick), 32'd1);
    goto_edge(9);  chk("tick9", 32'(bus.scan_tick), 32'd0);
    goto_edge(11); check_out("dig1_3", 4'b1101, 7'b0000110, 1'b1);
    goto_edge(16); chk("tick16", 32'(bus.scan_tick), 32'd1);
    goto_edge(19); check_out("dig2_A", 4'b1011, 7'b0001000, 1'b1);
    goto_edge(27); check_out("dig3_1", 4'b0111, 7'b1001111, 1'b1);

    // value without load has no effect
    goto_edge(28); bus.value = 16'hFFFF;
    goto_edge(29); check_out("noload", 4'b0111, 7'b1001111, 1'b1);

    // load in the last cycle of a slot lands in the next slot
    goto_edge(39); bus.load = 1'b1; bus.value = 16'h1A7F;
    goto_edge(40); bus.load = 1'b0;
    check_out("slot_end", 4'b1110, 7'b0111000, 1'b1);
    goto_edge(43); check_out("load_wrap", 4'b1101, 7'b0001111, 1'b1);

    // leading-zero blanking
    goto_edge(47); bus.lzb = 1'b1; bus.load = 1'b1; bus.value = 16'h0050;
    goto_edge(48); bus.load = 1'b0;
    goto_edge(53); check_out("lzb_d2", 4'b1111, 7'b1111111, 1'b1);
    goto_edge(61); check_out("lzb_d3", 4'b1111, 7'b1111111, 1'b1);
    goto_edge(67); check_out("lzb_d0", 4'b1110, 7'b0000001, 1'b1);
    goto_edge(75); check_out("lzb_d1", 4'b1101, 7'b0100100, 1'b1);
    goto_edge(79); bus.load = 1'b1; bus.value = 16'h0000;
    goto_edge(80); bus.load = 1'b0;
    goto_edge(99);  check_out("zero_d0", 4'b1110, 7'b0000001, 1'b1);
    goto_edge(107); check_out("zero_d1", 4'b1111, 7'b1111111, 1'b1);

    // decimal point with digit 2 disabled, then enabled mid-slot
    goto_edge(111); bus.lzb = 1'b0; bus.dp = 4'b0100; bus.dig_en = 4'b1011;
    bus.load = 1'b1; bus.value = 16'h1234;
    goto_edge(112); bus.load = 1'b0;
    goto_edge(115); check_out("den_d2_off", 4'b1111, 7'b1111111, 1'b1);
    goto_edge(116); bus.dig_en = 4'b1111;
    goto_edge(117); check_out("den_live", 4'b1011, 7'b0010010, 1'b0);

    // asynchronous reset at cnt=5, idx=2
    goto_edge(149); check_out("pre_rst", 4'b1011, 7'b0010010, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 4'b1111, 7'b1111111, 1'b1);
    chk("async_rst_tick", 32'(bus.scan_tick), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto_edge(2); check_out("post_rst_dead", 4'b1111, 7'b1111111, 1'b1);
    goto_edge(3); check_out("post_rst", 4'b1110, 7'b0000001, 1'b1);
    goto_edge(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
